dcache_miss_unit: RTL

//  Upstream of the AXI bus bridge on the DCache side. Accepts one miss/uncached request at a time from the DCache,

---
 rtl/dcache_miss_unit_pkg.sv | 16 +
 rtl/dcache_miss_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dcache_miss_unit_pkg.sv
// dcache_miss_unit_pkg: request-type, state and bridge request-line encodings
// shared by the DCache miss sequencer.
package dcache_miss_unit_pkg;
  localparam logic [1:0] DMISS_LINE = 2'b00;
  localparam logic [1:0] DMISS_UNCR = 2'b01;
  localparam logic [1:0] DMISS_UNCW = 2'b10;
  // One-hot request-line vector order: {DWriteUncache, DcaWriteAble, DUnacheRead, DcaReadAble}
  localparam logic [3:0] RQ_RD_LINE = 4'b0001;
  localparam logic [3:0] RQ_RD_UNC  = 4'b0010;
  localparam logic [3:0] RQ_WR_LINE = 4'b0100;
  localparam logic [3:0] RQ_WR_UNC  = 4'b1000;
  typedef enum logic [3:0] {
    S_IDLE, S_WB_REQ, S_WB_WAIT, S_RF_REQ, S_RF_WAIT,
    S_UR_REQ, S_UR_WAIT, S_UW_REQ, S_UW_WAIT, S_DONE
  } state_t;
endpackage

// File: rtl/dcache_miss_unit.sv
// dcache_miss_unit: sequences one DCache miss (victim writeback then refill) or one
// uncached word access through the AXI bridge and returns the result to the DCache.
module dcache_miss_unit
  import dcache_miss_unit_pkg::*;
#(
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 Clk,
  input  logic                 Rest,
  input  logic                 ReqValid,
  input  logic [1:0]           ReqType,
  input  logic [ADDR_W-1:0]    ReqAddr,
  input  logic                 ReqDirty,
  input  logic [ADDR_W-1:0]    VicAddr,
  input  logic [LINE_BITS-1:0] VicData,
  input  logic [31:0]          UncWdata,
  input  logic [3:0]           UncStrb,
  output logic                 ReqReady,
  output logic                 RespValid,
  output logic [LINE_BITS-1:0] RespLine,
  output logic [31:0]          RespWord,
  input  logic                 CacReadfree,
  input  logic                 CacWritefree,
  output logic                 DcaReadAble,
  output logic                 DUnacheRead,
  output logic [ADDR_W-1:0]    DcaReadAddr,
  input  logic                 DRshankhand,
  input  logic                 ReadBackAble,
  input  logic [511:0]         ReadBackDate,
  output logic                 DcaWriteAble,
  output logic                 DWriteUncache,
  output logic [ADDR_W-1:0]    DcaWriteAddr,
  output logic [LINE_BITS-1:0] DcaWDate,
  output logic [3:0]           UncacheStrb,
  input  logic                 DWshankhand,
  input  logic                 WritBAckAble
);
  state_t                r_state, w_next;
  logic [3:0]            r_req, w_req_next, w_req_sel;
  logic                  w_is_wr, w_is_req, w_free, w_shake, w_launch, w_accept, w_handed;
  logic [ADDR_W-1:0]     r_addr, r_vic_addr, r_rd_addr, r_wr_addr;
  logic [LINE_BITS-1:0]  r_vic_data, r_wdate, r_resp_line;
  logic [31:0]           r_wdata, r_resp_word;
  logic [3:0]            r_strb, r_ustrb;
  logic                  w_unused;

  assign w_unused = ^ReadBackDate[511:LINE_BITS];

  always_comb begin
    w_is_wr   = r_state inside {S_WB_REQ, S_UW_REQ};
    w_is_req  = w_is_wr || (r_state inside {S_RF_REQ, S_UR_REQ});
    w_free    = w_is_wr ? CacWritefree : CacReadfree;
    w_shake   = w_is_wr ? DWshankhand : DRshankhand;
    w_req_sel = (r_state == S_RF_REQ) ? RQ_RD_LINE :
                (r_state == S_UR_REQ) ? RQ_RD_UNC  :
                (r_state == S_WB_REQ) ? RQ_WR_LINE :
                (r_state == S_UW_REQ) ? RQ_WR_UNC  : 4'b0000;
    w_launch  = w_is_req && (r_req == 4'b0000) && w_free;
    w_handed  = (r_req != 4'b0000) && w_shake;
    w_accept  = (r_state == S_IDLE) && ReqValid && (ReqType != 2'b11);
    // The request line rises once the channel is free and falls on the handshake edge.
    w_req_next = w_launch ? w_req_sel : w_handed ? 4'b0000 : r_req;
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = (ReqType == DMISS_UNCR) ? S_UR_REQ :
                                        (ReqType == DMISS_UNCW) ? S_UW_REQ :
                                        ReqDirty ? S_WB_REQ : S_RF_REQ;
      S_WB_REQ:  if (w_handed) w_next = S_WB_WAIT;
      S_RF_REQ:  if (w_handed) w_next = S_RF_WAIT;
      S_UR_REQ:  if (w_handed) w_next = S_UR_WAIT;
      S_UW_REQ:  if (w_handed) w_next = S_UW_WAIT;
      S_WB_WAIT: if (WritBAckAble) w_next = S_RF_REQ;
      S_UW_WAIT: if (WritBAckAble) w_next = S_DONE;
      S_RF_WAIT: if (ReadBackAble) w_next = S_DONE;
      S_UR_WAIT: if (ReadBackAble) w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rest)
    if (!Rest) r_state <= S_IDLE;
    else r_state <= w_next;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_req       <= '0;
      r_addr      <= '0;
      r_vic_addr  <= '0;
      r_vic_data  <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wdate     <= '0;
      r_ustrb     <= '0;
      r_resp_line <= '0;
      r_resp_word <= '0;
    end else begin
      r_req <= w_req_next;
      if (w_accept) begin
        r_addr     <= ReqAddr;
        r_vic_addr <= VicAddr;
        r_vic_data <= VicData;
        r_wdata    <= UncWdata;
        r_strb     <= UncStrb;
      end
      if (w_launch && !w_is_wr) r_rd_addr <= r_addr;
      if (w_launch && w_is_wr) begin
        r_wr_addr <= (r_state == S_WB_REQ) ? r_vic_addr : r_addr;
        r_wdate   <= (r_state == S_WB_REQ) ? r_vic_data : {{(LINE_BITS-32){1'b0}}, r_wdata};
        r_ustrb   <= (r_state == S_WB_REQ) ? 4'hf : r_strb;
      end
      if (r_state == S_RF_WAIT && ReadBackAble) r_resp_line <= ReadBackDate[LINE_BITS-1:0];
      if (r_state == S_UR_WAIT && ReadBackAble) r_resp_word <= ReadBackDate[31:0];
    end
  end

  assign {DWriteUncache, DcaWriteAble, DUnacheRead, DcaReadAble} = r_req;
  assign DcaReadAddr  = r_rd_addr;
  assign DcaWriteAddr = r_wr_addr;
  assign DcaWDate     = r_wdate;
  assign UncacheStrb  = r_ustrb;
  assign ReqReady     = (r_state == S_IDLE);
  assign RespValid    = (r_state == S_DONE);
  assign RespLine     = r_resp_line;
  assign RespWord     = r_resp_word;

  a_one_req: assert property (@(posedge Clk) disable iff (!Rest) $onehot0(r_req));
endmodule
